// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider. Divisor updates take effect only at period boundaries.
// Defining CLKDIV_DUTY_EN adds a per-channel high-threshold register written through wr_duty_i.
module multi_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 100000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic              wr_en_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic [CNT_W-1:0]  wr_div_i,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0]  wr_duty_i,
`endif
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] pending_o
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Channel numbers that do not exist are dropped here, before any per-channel decode.
    logic wr_ok;
    assign wr_ok = wr_en_i && (int'(wr_ch_i) < NUM_CH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_q, act_d;
        logic [CNT_W-1:0] pend_q, pend_d;
        logic [CNT_W-1:0] new_div;
        logic [CNT_W-1:0] last_q, last_d;
        logic [CNT_W-1:0] thr_d;
        logic             pend_flag_q, pend_flag_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             hit;
        logic             stopped;
        logic             wrap;
        logic             apply;
        logic             have_pend;
        logic             run_d;
`ifdef CLKDIV_DUTY_EN
        logic [CNT_W-1:0] hi_act_q, hi_act_d;
        logic [CNT_W-1:0] hi_pend_q, hi_pend_d;
        logic [CNT_W-1:0] new_hi;
`endif

        assign hit = wr_ok && (wr_ch_i == CH_W'(c));

        always_comb begin
            stopped     = (act_q <= ONE);
            // Divisors 0 and 1 never reach the subtraction result, so it cannot underflow.
            last_q      = stopped ? '0 : act_q - ONE;
            wrap        = en_i && !stopped && (cnt_q == last_q);
            apply       = sync_i || stopped || wrap;
            have_pend   = hit || pend_flag_q;
            new_div     = hit ? wr_div_i : pend_q;
            pend_d      = new_div;
            act_d       = (apply && have_pend) ? new_div : act_q;
            pend_flag_d = have_pend && !apply;
`ifdef CLKDIV_DUTY_EN
            new_hi      = hit ? wr_duty_i : hi_pend_q;
            hi_pend_d   = new_hi;
            hi_act_d    = (apply && have_pend) ? new_hi : hi_act_q;
`endif
            if (apply) begin
                cnt_d = '0;
            end else if (en_i) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = cnt_q;
            end

            // Outputs are computed from the post-edge state so they can be registered.
            run_d  = (act_d > ONE);
            last_d = run_d ? act_d - ONE : '0;
`ifdef CLKDIV_DUTY_EN
            thr_d  = hi_act_d;
`else
            thr_d  = act_d >> 1;
`endif
            clk_d  = !sync_i && run_d && (cnt_d >= thr_d);
            tick_d = en_i && !sync_i && run_d && (cnt_d == last_d);
        end

        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                cnt_q       <= '0;
                act_q       <= DEF_DIV;
                pend_q      <= DEF_DIV;
                pend_flag_q <= 1'b0;
                clk_q       <= 1'b0;
                tick_q      <= 1'b0;
`ifdef CLKDIV_DUTY_EN
                hi_act_q    <= DEF_DIV >> 1;
                hi_pend_q   <= DEF_DIV >> 1;
`endif
            end else begin
                cnt_q       <= cnt_d;
                act_q       <= act_d;
                pend_q      <= pend_d;
                pend_flag_q <= pend_flag_d;
                clk_q       <= clk_d;
                tick_q      <= tick_d;
`ifdef CLKDIV_DUTY_EN
                hi_act_q    <= hi_act_d;
                hi_pend_q   <= hi_pend_d;
`endif
            end
        end

        assign clk_o[c]     = clk_q;
        assign tick_o[c]    = tick_q;
        assign pending_o[c] = pend_flag_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: a 4-channel main instance plus a 3-channel instance that
// exercises out-of-range channel writes; a spec-level model is checked every cycle.
module tb_multi_clock_divider;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sync;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic       wr_en3;
    logic [1:0] wr_ch3;
    logic [7:0] wr_duty;
    logic [3:0] clk_o, tick_o, pending_o;
    logic [2:0] clk_s, tick_s, pend_s;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {pending, tick, clk} of one channel for hand-computed sequences.
    logic [2:0] exp_q[$];

    // Model state: indices 0..3 are the main instance, 4..6 the small one.
    int m_cnt[7];
    int m_div[7];
    int m_pdiv[7];
    bit m_pend[7];
    bit m_clk[7];
    bit m_tick[7];
    bit m_valid = 1'b0;

    assign wr_duty = wr_div >> 1;

    multi_clock_divider #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(4)) u_dut (
        .clock_i  (clk),
        .reset_i  (rst),
        .en_i     (en),
        .sync_i   (sync),
        .wr_en_i  (wr_en),
        .wr_ch_i  (wr_ch),
        .wr_div_i (wr_div),
`ifdef CLKDIV_DUTY_EN
        .wr_duty_i(wr_duty),
`endif
        .clk_o    (clk_o),
        .tick_o   (tick_o),
        .pending_o(pending_o)
    );

    multi_clock_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) u_small (
        .clock_i  (clk),
        .reset_i  (rst),
        .en_i     (en),
        .sync_i   (sync),
        .wr_en_i  (wr_en3),
        .wr_ch_i  (wr_ch3),
        .wr_div_i (wr_div),
`ifdef CLKDIV_DUTY_EN
        .wr_duty_i(wr_duty),
`endif
        .clk_o    (clk_s),
        .tick_o   (tick_s),
        .pending_o(pend_s)
    );

    // Clock and reset-related defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is a position within a period of length div.
    always @(posedge clk) begin
        for (int c = 0; c < 7; c++) begin
            bit hit;
            bit running;
            bit boundary;
            if (c < 4) hit = wr_en && (int'(wr_ch) == c);
            else       hit = wr_en3 && (int'(wr_ch3) < 3) && (int'(wr_ch3) == c - 4);
            if (rst) begin
                m_cnt[c]  = 0;
                m_div[c]  = 4;
                m_pend[c] = 1'b0;
                m_clk[c]  = 1'b0;
                m_tick[c] = 1'b0;
                m_valid   = 1'b1;
            end else begin
                if (hit) begin
                    m_pdiv[c] = int'(wr_div);
                    m_pend[c] = 1'b1;
                end
                running  = (m_div[c] >= 2);
                boundary = sync || !running || (en && m_cnt[c] == m_div[c] - 1);
                if (sync || !running) m_cnt[c] = 0;
                else if (en)          m_cnt[c] = (m_cnt[c] + 1) % m_div[c];
                if (boundary && m_pend[c]) begin
                    m_div[c]  = m_pdiv[c];
                    m_pend[c] = 1'b0;
                end
                running   = (m_div[c] >= 2);
                m_clk[c]  = !sync && running && (m_cnt[c] >= m_div[c] / 2);
                m_tick[c] = en && !sync && running && (m_cnt[c] == m_div[c] - 1);
            end
        end
    end

    // Compare process on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            logic [3:0] e_clk, e_tick, e_pend, s_clk, s_tick, s_pend;
            for (int c = 0; c < 4; c++) begin
                e_clk[c]  = m_clk[c];
                e_tick[c] = m_tick[c];
                e_pend[c] = m_pend[c];
            end
            s_clk  = 4'b0;
            s_tick = 4'b0;
            s_pend = 4'b0;
            for (int c = 0; c < 3; c++) begin
                s_clk[c]  = m_clk[c + 4];
                s_tick[c] = m_tick[c + 4];
                s_pend[c] = m_pend[c + 4];
            end
            chk("model_clk",        clk_o,            e_clk);
            chk("model_tick",       tick_o,           e_tick);
            chk("model_pending",    pending_o,        e_pend);
            chk("model_small_clk",  {1'b0, clk_s},    s_clk);
            chk("model_small_tick", {1'b0, tick_s},   s_tick);
            chk("model_small_pend", {1'b0, pend_s},   s_pend);
        end
    end

    // Driver tasks: all start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int div);
        wr_en  = 1'b1;
        wr_ch  = 2'(ch);
        wr_div = 8'(div);
        step(1);
        wr_en  = 1'b0;
    endtask

    task automatic lit_seq(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            logic [2:0] e;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL lit_seq: expectation queue empty for ch%0d", ch);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("ch%0d_seq%0d", ch, i),
                    {1'b0, pending_o[ch], tick_o[ch], clk_o[ch]}, {1'b0, e});
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        sync   = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = 2'd0;
        wr_div = 8'd0;
        wr_en3 = 1'b0;
        wr_ch3 = 2'd0;
        step(2);
        chk("reset_clk",     clk_o,     4'b0000);
        chk("reset_tick",    tick_o,    4'b0000);
        chk("reset_pending", pending_o, 4'b0000);
        rst = 1'b0;
        en  = 1'b1;

        // Default divisor 4: clk 0,0,1,1 with tick on the last count.
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0, 1:    exp_q.push_back(3'b000);
                2:       exp_q.push_back(3'b001);
                default: exp_q.push_back(3'b011);
            endcase
        end
        lit_seq(0, 16);
        step(1);

        // ch1 := 5 written at count 1; waits for the wrap, then 2 low + 3 high.
        step(1);
        wr(1, 5);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b111);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b000);
        lit_seq(1, 8);
        step(1);

        // ch2 := 0 stops at the wrap; a later write of 6 takes effect on its own edge.
        wr(2, 0);
        exp_q.push_back(3'b111);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        lit_seq(2, 3);
        step(1);
        wr(2, 6);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b000);
        lit_seq(2, 7);

        // Freeze ch2 at count 3 for 7 edges, then resume from that count.
        step(3);
        en = 1'b0;
        for (int i = 0; i < 7; i++) exp_q.push_back(3'b001);
        lit_seq(2, 7);
        step(1);
        en = 1'b1;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b000);
        lit_seq(2, 4);

        // Write ch3 := 8 on the sync edge: applied immediately, all channels restart.
        step(1);
        wr_en  = 1'b1;
        wr_ch  = 2'd3;
        wr_div = 8'd8;
        sync   = 1'b1;
        step(1);
        wr_en  = 1'b0;
        sync   = 1'b0;
        chk("sync_pending", pending_o, 4'b0000);
        chk("sync_clk",     clk_o,     4'b0000);
        chk("sync_tick",    tick_o,    4'b0000);
        for (int i = 0; i < 9; i++) begin
            if (i < 4 || i == 8) exp_q.push_back(3'b000);
            else if (i < 7)      exp_q.push_back(3'b001);
            else                 exp_q.push_back(3'b011);
        end
        lit_seq(3, 9);
        step(1);

        // Small instance has 3 channels: channel 3 does not exist and is ignored.
        wr_en3 = 1'b1;
        wr_ch3 = 2'd3;
        wr_div = 8'd2;
        step(1);
        chk("ignored_write_pend", {1'b0, pend_s}, 4'b0000);
        wr_ch3 = 2'd2;
        wr_div = 8'd3;
        step(1);
        wr_en3 = 1'b0;
        chk("valid_write_pend", {1'b0, pend_s}, 4'b0100);

        // Reset with a pending write: the default divisor of 4 comes back.
        step(1);
        wr(0, 7);
        chk("pend_before_reset", pending_o, 4'b0001);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("reset2_pending",  pending_o,        4'b0000);
        chk("reset2_clk",      clk_o,            4'b0000);
        chk("reset2_tick",     tick_o,           4'b0000);
        chk("reset2_small_pd", {1'b0, pend_s},   4'b0000);
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0, 1:    exp_q.push_back(3'b000);
                2:       exp_q.push_back(3'b001);
                default: exp_q.push_back(3'b011);
            endcase
        end
        lit_seq(0, 8);
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
